// File: rtl/sram_6116_master.sv
// Sequencer that turns one valid/ready request at a time into a timed 6116-style
// SRAM cycle (SETUP, ACCESS, HOLD), with every SRAM-facing signal driven from a flop.
module sram_6116_master #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Din,
  input  logic [DATA_W-1:0] Dout,
  output logic              CS_b,
  output logic              WE_b,
  output logic              OE_b,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is taken on the rising clk edge where req_valid && req_ready.
  // req_ready is high only in IDLE; requests seen while busy are ignored, never queued.

  localparam int MAX_CYC = (SETUP_CYC > ACCESS_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((ACCESS_CYC > HOLD_CYC) ? ACCESS_CYC : HOLD_CYC);
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_we_q, op_we_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                cs_b_q, cs_b_d;
  logic                we_b_q, we_b_d;
  logic                oe_b_q, oe_b_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                last_cyc;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_we_d     = op_we_q;
    a_d         = a_q;
    din_d       = din_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    last_cyc    = (cnt_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
          op_we_d = req_we;
          a_d     = req_addr;
          if (req_we) din_d = req_wdata;
        end
      end
      ST_SETUP: begin
        if (last_cyc) begin
          state_d = ST_ACCESS;
          cnt_d   = ACCESS_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        // The edge closing the last strobe cycle samples read data and raises the pulse.
        if (last_cyc) begin
          state_d     = ST_HOLD;
          cnt_d       = HOLD_LD;
          rsp_valid_d = 1'b1;
          if (!op_we_q) rsp_rdata_d = Dout;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (last_cyc) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they change exactly with state.
    cs_b_d = (state_d == ST_IDLE);
    we_b_d = !((state_d == ST_ACCESS) && op_we_d);
    oe_b_d = !((state_d == ST_ACCESS) && !op_we_d);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_we_q     <= 1'b0;
      a_q         <= '0;
      din_q       <= '0;
      cs_b_q      <= 1'b1;
      we_b_q      <= 1'b1;
      oe_b_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_we_q     <= op_we_d;
      a_q         <= a_d;
      din_q       <= din_d;
      cs_b_q      <= cs_b_d;
      we_b_q      <= we_b_d;
      oe_b_q      <= oe_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign A         = a_q;
  assign Din       = din_q;
  assign CS_b      = cs_b_q;
  assign WE_b      = we_b_q;
  assign OE_b      = oe_b_q;
  assign dbg_state = state_q;

endmodule
